// File: rtl/divdisp_pkg.sv
// Shared types and segment constants for the divider result display.
// Output polarity follows DIVDISP_ACTIVE_LOW_EN (defined: common-anode, active-low).
package divdisp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

`ifdef DIVDISP_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;
`else
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [1:0] AN_OFF  = 2'b00;
`endif

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
  import divdisp_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  // Hex lookup
  always_comb begin
    o_seg = SEG_0;
    case (i_val)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/div_result_display.sv
// Captures divider quotient/remainder on done rising edge and multiplexes them
// onto a two-digit 7-segment display. DIVDISP_ACTIVE_LOW_EN selects active-low outputs.
module div_result_display
  import divdisp_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int REFRESH_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] M,
  input  logic             done,
  output logic [6:0]       seg,
  output logic [1:0]       an,
  output logic             valid
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_done_q;
  logic [3:0]    r_d;
  logic [3:0]    r_m;
  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic          w_cap;
  logic          w_wrap;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic [6:0]    w_seg_nxt;
  logic [1:0]    w_an_nxt;

  assign w_cap   = done & ~r_done_q;
  assign w_wrap  = (r_cnt == CNT_MAX);
  assign w_digit = r_sel ? r_m : r_d;

  seg7_decode u_dec (
    .i_val (w_digit),
    .o_seg (w_seg_dec)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BLANK;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: only reset leaves SHOW
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BLANK:   w_state_nxt = w_cap ? SHOW : BLANK;
      SHOW:    w_state_nxt = SHOW;
      default: w_state_nxt = BLANK;
    endcase
  end

  // Capture registers, edge detect and refresh timing; capture wins over wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_q <= 1'b0;
      r_d      <= 4'h0;
      r_m      <= 4'h0;
      r_cnt    <= '0;
      r_sel    <= 1'b0;
      valid    <= 1'b0;
    end else begin
      r_done_q <= done;
      if (w_cap) begin
        r_d   <= 4'(D);
        r_m   <= 4'(M);
        valid <= 1'b1;
        r_cnt <= '0;
        r_sel <= 1'b0;
      end else if (r_state == SHOW) begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_sel <= ~r_sel;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // Active-high display value before the output register
  always_comb begin
    w_seg_nxt = 7'h00;
    w_an_nxt  = 2'b00;
    if (r_state == SHOW) begin
      w_seg_nxt = w_seg_dec;
      w_an_nxt  = r_sel ? 2'b01 : 2'b10;
    end else begin
      w_seg_nxt = 7'h00;
      w_an_nxt  = 2'b00;
    end
  end

  // Output register, polarity applied here only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
`ifdef DIVDISP_ACTIVE_LOW_EN
      seg <= ~w_seg_nxt;
      an  <= ~w_an_nxt;
`else
      seg <= w_seg_nxt;
      an  <= w_an_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_div_result_display.sv
// Directed self-checking bench for div_result_display; follows DIVDISP_ACTIVE_LOW_EN.
module tb_div_result_display;

`ifdef DIVDISP_ACTIVE_LOW_EN
  localparam int RDIV = 4;
  localparam bit ALOW = 1'b1;
`else
  localparam int RDIV = 16;
  localparam bit ALOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] D;
  logic [2:0] M;
  logic       done;
  logic [6:0] seg;
  logic [1:0] an;
  logic       valid;
  int         n_cmp = 0;
  int         n_err = 0;

  div_result_display #(.WIDTH(3), .REFRESH_DIV(RDIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .D     (D),
    .M     (M),
    .done  (done),
    .seg   (seg),
    .an    (an),
    .valid (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return ALOW ? ~s : s;
  endfunction

  function automatic logic [1:0] an_exp(input int digit);
    logic [1:0] a;
    a = (digit == 0) ? 2'b10 : 2'b01;
    return ALOW ? ~a : a;
  endfunction

  function automatic logic [6:0] seg_off();
    return ALOW ? 7'h7F : 7'h00;
  endfunction

  function automatic logic [1:0] an_off();
    return ALOW ? 2'b11 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk nslots digit slots starting with the quotient, checking every cycle
  task automatic check_slots(input string tag, input logic [3:0] d, input logic [3:0] m,
                             input int nslots);
    for (int s = 0; s < nslots; s++) begin
      for (int i = 0; i < RDIV; i++) begin
        tick();
        chk({tag, "_seg"}, 32'(seg), 32'(hex7((s % 2 == 0) ? d : m)));
        chk({tag, "_an"},  32'(an),  32'(an_exp(s % 2)));
      end
    end
  endtask

  initial begin
    rst = 1'b0; D = 3'd0; M = 3'd0; done = 1'b0;
    repeat (3) tick();
    chk("rst_seg", 32'(seg), 32'(seg_off()));
    chk("rst_an", 32'(an), 32'(an_off()));
    chk("rst_valid", 32'(valid), 32'd0);

    rst = 1'b1;
    repeat (50) tick();
    chk("idle_seg", 32'(seg), 32'(seg_off()));
    chk("idle_an", 32'(an), 32'(an_off()));
    chk("idle_valid", 32'(valid), 32'd0);

    // First result: 7/2 = 3 r 1
    D = 3'd3; M = 3'd1; done = 1'b1;
    tick();
    done = 1'b0;
    chk("cap_valid", 32'(valid), 32'd1);
    chk("cap_an_lag", 32'(an), 32'(an_off()));
    check_slots("first", 4'd3, 4'd1, 3);

    // Level done: one capture only, later D change ignored
    D = 3'd3; M = 3'd2; done = 1'b1;
    tick();
    D = 3'd5;
    check_slots("level", 4'd3, 4'd2, 2);
    repeat (8) tick();
    done = 1'b0;
    repeat (3) tick();
    D = 3'd5; M = 3'd4; done = 1'b1;
    tick();
    done = 1'b0;
    check_slots("d5", 4'd5, 4'd4, 2);

    // Capture lands on a refresh wrap edge: quotient slot must restart
    repeat (RDIV - 1) tick();
    D = 3'd6; M = 3'd3; done = 1'b1;
    tick();
    done = 1'b0;
    check_slots("wrapcap", 4'd6, 4'd3, 2);

    // Asynchronous reset mid-display, release with done already high
    #2 rst = 1'b0;
    #1;
    chk("arst_seg", 32'(seg), 32'(seg_off()));
    chk("arst_an", 32'(an), 32'(an_off()));
    chk("arst_valid", 32'(valid), 32'd0);
    D = 3'd2; M = 3'd1; done = 1'b1;
    repeat (2) tick();
    chk("inrst_seg", 32'(seg), 32'(seg_off()));
    rst = 1'b1;
    tick();
    chk("rel_valid", 32'(valid), 32'd1);
    check_slots("rel", 4'd2, 4'd1, 2);
    done = 1'b0;
    tick();

    // Digit 7 (active-low build: 78 on an=01)
    D = 3'd7; M = 3'd0; done = 1'b1;
    tick();
    done = 1'b0;
    check_slots("d7", 4'd7, 4'd0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_result_display.md
# div_result_display

Downstream consumer of the 3-bit restoring divider. It captures the quotient `D` and remainder `M` on the rising edge of the divider's `done`, and holds them until the next result. It time-multiplexes both values onto a two-digit 7-segment display. Before the first result after reset the display stays blank.

## Interface
- `WIDTH`, default 3: operand width of `D`/`M`; legal range 1..4, and values are zero-extended to 4 bits before decoding.
- `REFRESH_DIV`, default 16: clock cycles each digit stays lit; must be ≥2.

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets immediately, independent of `clk`).
- `D`  in  WIDTH  quotient from the divider.
- `M`  in  WIDTH  remainder from the divider.
- `done`  in  1  divider completion level; may stay high any number of cycles.
- `seg`  out  7  segment drive `{g,f,e,d,c,b,a}`.
- `an`  out  2  digit enables; `an[1]`=quotient (left), `an[0]`=remainder (right).
- `valid`  out  1  high once at least one result has been captured since reset.

## Operation
- **Reset** (`rst`=0), all registered and immediate:
  - `seg`, `an`: inactive.
  - `valid`, `done_q`, `d_reg`, `m_reg`, refresh counter, digit select: all 0.
  - FSM → `BLANK`.
- **Edge detect:** `done_q` <= `done` every cycle. Capture condition is `done`=1 && `done_q`=0.
  - `done` already high at the first edge after reset release counts as a rising edge.
  - `done` held high captures once only.
- **FSM:**
  - `BLANK`: outputs inactive. On capture → `SHOW`.
  - `SHOW`: displays the registers. On capture it stays in `SHOW` and reloads. Only reset leaves `SHOW`.
- **On capture:**
  - `d_reg` <= `D`, `m_reg` <= `M`, `valid` <= 1.
  - Refresh counter <= 0; digit select <= 0, meaning quotient first.
- **Refresh (in `SHOW`):**
  - Counter counts 0..`REFRESH_DIV`-1, then wraps to 0.
  - On wrap, digit select toggles.
  - Capture takes priority over wrap when both occur on the same edge.
- **Digit 0:** `an`=2'b10 active, `seg`=decode(`d_reg`). **Digit 1:** `an`=2'b01 active, `seg`=decode(`m_reg`).
- **Decode**, active-high hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- `D`/`M` are sampled only on the capture edge; changes at other times are ignored.

## Timing
- Capture at edge k. `valid`=1 after edge k.
- `seg`/`an` are registered and show the new quotient after edge k+1. This is 1 cycle latency from capture to display.
- Each digit is lit for exactly `REFRESH_DIV` cycles. Full refresh period is 2·`REFRESH_DIV`.
- The first digit after a capture lasts `REFRESH_DIV` cycles, counted from edge k.
- Reset asserted mid-display blanks outputs immediately. The first result after reset release requires a fresh `done` rising edge, or `done` high at the first edge.
- `an` never has both digits active at once, including in the cycle where the digit switches.

## Configuration
- Macro `DIVDISP_ACTIVE_LOW_EN`.
- **Defined:** `seg` and `an` are inverted at the output register for common-anode boards. "Inactive" is 7'h7F / 2'b11, and the active digit is driven 0.
- **Undefined:** active-high as written above. Inactive is 7'h00 / 2'b00.
- Internal state and `valid` are identical in both builds.

## Structure
- Package `divdisp_pkg`:
  - FSM state typedef `{BLANK, SHOW}`.
  - The 16 segment constants.
  - `SEG_OFF`, `AN_OFF`, resolved from `DIVDISP_ACTIVE_LOW_EN`.
- Sub-module `seg7_decode`: purely combinational 4-bit → 7-bit, active-high; instantiated once on the muxed digit value.
- Polarity inversion happens only in the top-level output register.

## Test plan
- **Reset state:** hold `rst`=0 for 3 cycles → `seg`=inactive, `an`=inactive, `valid`=0. Release without `done` for 50 cycles → still blank.
- **First result:** `D`=3, `M`=1, pulse `done` for 1 cycle at edge k (7/2) →
  - `valid`=1 after edge k.
  - `an`=10 with `seg`=4F from edge k+1 for 16 cycles.
  - Then `an`=01 with `seg`=06 for 16 cycles, and alternating after that.
- **Level done:** hold `done`=1 for 40 cycles while changing `D` from 3 to 5 mid-pulse → display keeps 3. A new `done` rising edge with `D`=5 → quotient digit shows 6D.
- **Simultaneous events:** issue the capture on the same edge as a refresh wrap → digit select = 0 and counter = 0, with the full 16-cycle quotient slot.
- **Reset mid-operation:** assert `rst` while in `SHOW` → outputs blank immediately. Release with `done` already high → capture at the first edge, and the display shows the sampled values.
- **Build variants:** rebuild with `DIVDISP_ACTIVE_LOW_EN` and `REFRESH_DIV`=4 →
  - Reset outputs are 7F / 11.
  - `D`=7 gives `seg`=78 on `an`=01.
  - Digit slots are 4 cycles each.
